serial_addsub_acc: RTL

- Bit-serial add/subtract accumulator that consumes operands and forms their two's complement on the fly for subtraction: invert each bit, seed the carry with a fixed 1.
- Sits downstream of the combinational 1's/2's complement stage in the lab datapath.
- Holds a WIDTH-bit signed running accumulator.
- Exchanges operands and results over valid/ready handshakes.

---
 rtl/serial_addsub_pkg.sv | 22 ++
 rtl/serial_addsub_acc_if.sv | 27 ++
 rtl/fa_bit.sv | 11 +
 rtl/serial_addsub_acc.sv | 114 +++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract accumulator:
// operation codes, FSM state encoding and a counter-width helper.
package serial_addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_addsub_acc_if.sv
// Operand/result handshake bundle for serial_addsub_acc.
// master = operand producer / result consumer, slave = the accumulator.
interface serial_addsub_acc_if #(
   parameter int WIDTH = 3
) ();
   logic                    in_valid;
   logic                    in_ready;
   logic        [WIDTH-1:0] in_b;
   logic                    in_op;
   logic                    in_clr;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] result;
   logic                    cout;
   logic                    ovf;
   logic                    sticky_ovf;

   modport master (
      output in_valid, in_b, in_op, in_clr, out_ready,
      input  in_ready, out_valid, result, cout, ovf, sticky_ovf
   );

   modport slave (
      input  in_valid, in_b, in_op, in_clr, out_ready,
      output in_ready, out_valid, result, cout, ovf, sticky_ovf
   );
endinterface

// File: rtl/fa_bit.sv
// Combinational one-bit full adder used as the serial add/subtract cell.
module fa_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_addsub_acc.sv
// Bit-serial add/subtract accumulator. One operand bit per cycle, LSB
// first; subtraction is done as acc + ~b + 1 by inverting each operand
// bit and seeding the carry with 1. Reports carry-out, signed overflow
// and a sticky overflow flag; results wrap rather than saturate.
module serial_addsub_acc
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input logic               clk,
   input logic               rst_n,
   serial_addsub_acc_if.slave bus
);

   localparam int CNT_W = clog2(WIDTH);

   state_t                  r_state;
   logic signed [WIDTH-1:0] r_acc;
   logic        [WIDTH-1:0] r_a;
   logic        [WIDTH-1:0] r_b;
   logic        [WIDTH-1:0] r_sum;
   logic                    r_op;
   logic                    r_c;
   logic        [CNT_W-1:0] r_cnt;
   logic signed [WIDTH-1:0] r_result;
   logic                    r_cout;
   logic                    r_ovf;
   logic                    r_sticky;
   logic                    r_out_valid;

   logic             w_bb;
   logic             w_sum;
   logic             w_carry;
   logic             w_last;
   logic [WIDTH-1:0] w_assembled;

   // Operand bit, conditionally inverted for subtraction
   assign w_bb        = r_b[0] ^ r_op;
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_assembled = {w_sum, r_sum[WIDTH-1:1]};

   fa_bit u_fa (
      .i_a   (r_a[0]),
      .i_b   (w_bb),
      .i_cin (r_c),
      .o_s   (w_sum),
      .o_cout(w_carry)
   );

   // Control FSM, serial datapath and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_op        <= OP_ADD;
         r_c         <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_sticky    <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.in_clr ? '0 : r_acc;
                  r_b     <= bus.in_b;
                  r_op    <= bus.in_op;
                  r_c     <= bus.in_op;
                  r_cnt   <= '0;
                  if (bus.in_clr) r_sticky <= 1'b0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_sum <= w_assembled;
               r_c   <= w_carry;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  // r_c here is the carry into the MSB position
                  r_acc       <= w_assembled;
                  r_result    <= w_assembled;
                  r_cout      <= w_carry;
                  r_ovf       <= r_c ^ w_carry;
                  r_sticky    <= r_sticky | (r_c ^ w_carry);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == IDLE);
   assign bus.out_valid  = r_out_valid;
   assign bus.result     = r_result;
   assign bus.cout       = r_cout;
   assign bus.ovf        = r_ovf;
   assign bus.sticky_ovf = r_sticky;

endmodule
